// File: rtl/aes_pkg.sv
// AES-128 constants and per-round transforms shared by the round unit and sequencer.
// State layout: byte i sits at [127-8*i -: 8], column-major (byte 4*c+r is row r, column c).
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    // Out-of-range rounds (idle counter) map to 0 so the unused chain stays defined.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++)
            if (r == 4'(i)) v = RCON[i];
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rkey, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[rkey[23:16]] ^ rcon, SBOX[rkey[15:8]], SBOX[rkey[7:0]], SBOX[rkey[31:24]]};
        n0 = rkey[127:96] ^ t;
        n1 = rkey[95:64] ^ n0;
        n2 = rkey[63:32] ^ n1;
        n3 = rkey[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round plus the matching key-schedule step.
// The final round skips MixColumns.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rkey,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] next_state,
    output logic [127:0] next_rkey
);
    logic [127:0] sr;

    assign next_rkey  = key_step(rkey, rcon);
    assign sr         = shift_rows(sub_bytes(state));
    assign next_state = (last ? sr : mix_columns(sr)) ^ next_rkey;
endmodule

// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encryptor: IDLE -> ROUND -> DONE with ROUNDS_PER_CYCLE chained round units.
// Optional macro AES_KEY_REUSE_EN adds key_load and a reset-only cleared key cache.
module aes_enc_sequencer
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit ZEROIZE          = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
`ifdef AES_KEY_REUSE_EN
    input  logic         key_load,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   round_idx
);
    fsm_t         fsm;
    logic [127:0] state_q, rkey_q, key_use, last_st, last_rk;
    logic         final_step;

`ifdef AES_KEY_REUSE_EN
    logic [127:0] key_cache;
    assign key_use = key_load ? in_key : key_cache;

    always_ff @(posedge clk) begin
        if (reset)                              key_cache <= '0;
        else if (fsm == IDLE && in_valid && key_load) key_cache <= in_key;
    end
`else
    assign key_use = in_key;
`endif

    genvar g;
    for (g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [127:0] st_i, rk_i, st_o, rk_o;
        logic [3:0]   rnd;
        if (g == 0) begin : g_src
            assign st_i = state_q;
            assign rk_i = rkey_q;
        end else begin : g_src
            assign st_i = g_rnd[g-1].st_o;
            assign rk_i = g_rnd[g-1].rk_o;
        end
        assign rnd = round_idx + 4'(g);
        aes_round_comb u_round (
            .state      (st_i),
            .rkey       (rk_i),
            .rcon       (rcon_of(rnd)),
            .last       (rnd == 4'd10),
            .next_state (st_o),
            .next_rkey  (rk_o)
        );
    end

    assign last_st    = g_rnd[ROUNDS_PER_CYCLE-1].st_o;
    assign last_rk    = g_rnd[ROUNDS_PER_CYCLE-1].rk_o;
    assign final_step = (round_idx + 4'(ROUNDS_PER_CYCLE - 1)) == 4'd10;

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            state_q   <= '0;
            rkey_q    <= '0;
            round_idx <= '0;
            out_block <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    state_q   <= in_block ^ key_use;
                    rkey_q    <= key_use;
                    round_idx <= 4'd1;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    state_q   <= last_st;
                    rkey_q    <= last_rk;
                    round_idx <= round_idx + 4'(ROUNDS_PER_CYCLE);
                    if (final_step) begin
                        out_block <= last_st;
                        fsm       <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    fsm       <= IDLE;
                    round_idx <= '0;
                    if (ZEROIZE) begin
                        state_q <= '0;
                        rkey_q  <= '0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
